// File: rtl/rbm_vote_accumulator.sv
// rbm_vote_accumulator: iteration controller and vote accumulator for
// stochastic RBM inference.
//
// Each iteration re-arms the downstream layer chain, waits for it to produce
// one sample, adds that sample's one-bit class votes into per-class
// saturating counters, then scans the counters for the argmax class.
// A run ends when the iteration limit is reached or, with the optional
// feature enabled, when the leading class is far enough ahead.
//
// Optional feature macro: RBM_VOTE_EARLY_STOP_EN
//   defined   -> early stop when margin != 0 and (best - second) >= margin
//   undefined -> margin is unused, early_stop stays 0
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start          begin a run (sampled only in IDLE)
//   iter_limit     maximum iterations, latched on accepted start
//   margin         early-stop lead threshold, latched on accepted start
//   layer_reset    reset to the layer chain (high = held in reset)
//   layer_finish   layer chain produced one sample
//   sample         one-bit class sample, valid with layer_finish
//   counts         packed counters, class i at [i*CNT_WIDTH +: CNT_WIDTH]
//   iter_count     iterations completed in the current or last run
//   winner         argmax class after the most recent scan
//   early_stop     last run ended on margin rather than on limit
//   busy           high in every state except IDLE and DONE
//   result_valid   results stable and available
//   result_ready   consumer accepts the result
module rbm_vote_accumulator #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_WIDTH   = 12,
  parameter int ITER_WIDTH  = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [ITER_WIDTH-1:0]            iter_limit,
  input  logic [CNT_WIDTH-1:0]             margin,
  output logic                             layer_reset,
  input  logic                             layer_finish,
  input  logic [NUM_CLASSES-1:0]           sample,
  output logic [NUM_CLASSES*CNT_WIDTH-1:0] counts,
  output logic [ITER_WIDTH-1:0]            iter_count,
  output logic [IDX_WIDTH-1:0]             winner,
  output logic                             early_stop,
  output logic                             busy,
  output logic                             result_valid,
  input  logic                             result_ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  logic [2:0]            state;
  logic [ITER_WIDTH-1:0] limit_q;
  logic [CNT_WIDTH-1:0]  cnt [NUM_CLASSES];

  logic [IDX_WIDTH-1:0]  scan_idx;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [CNT_WIDTH-1:0]  best_val;
  logic [CNT_WIDTH-1:0]  second_val;

  logic                  scan_first;
  logic [CNT_WIDTH-1:0]  cur_val;
  logic [CNT_WIDTH-1:0]  base_best;
  logic [CNT_WIDTH-1:0]  base_second;
  logic [IDX_WIDTH-1:0]  base_idx;
  logic [CNT_WIDTH-1:0]  nxt_best;
  logic [CNT_WIDTH-1:0]  nxt_second;
  logic [IDX_WIDTH-1:0]  nxt_idx;
  logic                  stop_margin;

  assign layer_reset  = (state != S_RUN);
  assign busy         = (state != S_IDLE) && (state != S_DONE);
  assign result_valid = (state == S_DONE);

  always_comb begin
    counts = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      counts[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end
  end

  // One scan step. The running best/second are restarted at class 0 so a
  // stale scan from the previous iteration never leaks in. A value equal
  // to the best does not take over (lower index wins) but does raise the
  // second-best, so a tie at the top gives a zero lead.
  always_comb begin
    scan_first  = (scan_idx == '0);
    cur_val     = cnt[scan_idx];
    base_best   = scan_first ? '0 : best_val;
    base_second = scan_first ? '0 : second_val;
    base_idx    = scan_first ? '0 : best_idx;
    nxt_best    = base_best;
    nxt_second  = base_second;
    nxt_idx     = base_idx;
    if (cur_val > base_best) begin
      nxt_best   = cur_val;
      nxt_idx    = scan_idx;
      nxt_second = base_best;
    end else if (cur_val > base_second) begin
      nxt_second = cur_val;
    end
  end

`ifdef RBM_VOTE_EARLY_STOP_EN
  logic [CNT_WIDTH-1:0] margin_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      margin_q <= '0;
    end else if (state == S_IDLE && start) begin
      margin_q <= margin;
    end
  end

  // nxt_best >= nxt_second always, so the subtraction cannot wrap.
  assign stop_margin = (margin_q != '0) &&
                       ((nxt_best - nxt_second) >= margin_q);
`else
  logic unused_margin;
  assign unused_margin = ^margin;
  assign stop_margin   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      limit_q    <= '0;
      iter_count <= '0;
      winner     <= '0;
      early_stop <= 1'b0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      second_val <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            limit_q    <= iter_limit;
            iter_count <= '0;
            winner     <= '0;
            early_stop <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
              cnt[i] <= '0;
            end
            state <= (iter_limit == '0) ? S_DONE : S_ARM;
          end
        end
        S_ARM: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (layer_finish) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              if (sample[i] && cnt[i] != CNT_MAX) begin
                cnt[i] <= cnt[i] + CNT_WIDTH'(1);
              end
            end
            iter_count <= iter_count + ITER_WIDTH'(1);
            scan_idx   <= '0;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          best_val   <= nxt_best;
          best_idx   <= nxt_idx;
          second_val <= nxt_second;
          if (scan_idx == LAST_IDX) begin
            winner   <= nxt_idx;
            scan_idx <= '0;
            if (iter_count == limit_q) begin
              early_stop <= 1'b0;
              state      <= S_DONE;
            end else if (stop_margin) begin
              early_stop <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_ARM;
            end
          end else begin
            scan_idx <= scan_idx + IDX_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (result_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
